mux2to1: RTL and testbench



---
 rtl/mux_pkg.sv | 12 +
 rtl/sat_counter.sv | 29 ++
 rtl/mux2to1.sv | 84 ++++++++
 tb/tb_mux2to1.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the mux2to1 slice: default sizes and select encoding.
package mux_pkg;

    localparam int unsigned DEF_WIDTH = 1;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

endpackage : mux_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (priority) and increment enable.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    // Held at all-ones once reached; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + W'(1);
        end
    end

    // Saturation flag follows the count directly.
    always_comb begin
        sat = &cnt;
    end

endmodule : sat_counter

// File: rtl/mux2to1.sv
// 2-to-1 mux: combinational output, registered copy and select-toggle counter.
// Optional macro MUX2TO1_SEL_SYNC_EN: two-flop synchroniser on the select
// feeding the registered path and toggle counter (o_Z always uses raw i_sel).
module mux2to1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_sel,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_Z,
    output logic [WIDTH-1:0] o_Z_q,
    output logic             o_sel_q,
    output logic [CNT_W-1:0] o_sw_cnt,
    output logic             o_sw_sat
);

    sel_e             sel_eff;
    sel_e             sel_q;
    logic [WIDTH-1:0] z_q;
    logic             toggle;

    // Raw conditional keeps standard X-merge behaviour when i_sel is unknown.
    assign o_Z = i_sel ? i_B : i_A;

`ifdef MUX2TO1_SEL_SYNC_EN
    logic [1:0] sel_sync;

    // Two-flop synchroniser on the select input.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sel_sync <= '0;
        end else begin
            sel_sync <= {sel_sync[0], i_sel};
        end
    end

    // Effective select is the synchronised copy.
    always_comb begin
        sel_eff = sel_e'(sel_sync[1]);
    end
`else
    // Effective select is the raw input.
    always_comb begin
        sel_eff = sel_e'(i_sel);
    end
`endif

    // Registered mux output and select; sel_q also serves as the previous select.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            z_q   <= '0;
            sel_q <= SEL_A;
        end else begin
            sel_q <= sel_eff;
            z_q   <= (sel_eff == SEL_B) ? i_B : i_A;
        end
    end

    // A toggle is any edge where the effective select differs from last cycle's.
    always_comb begin
        toggle = (sel_eff != sel_q);
    end

    assign o_Z_q   = z_q;
    assign o_sel_q = sel_q;

    sat_counter #(
        .W (CNT_W)
    ) u_sw_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (i_clr),
        .inc   (toggle),
        .cnt   (o_sw_cnt),
        .sat   (o_sw_sat)
    );

endmodule : mux2to1

// File: tb/tb_mux2to1.sv
// Scoreboard bench for mux2to1: an 8-bit instance (3-bit counter) and a
// 1-bit instance (2-bit counter) share clock, reset, select and clear.
module tb_mux2to1;

`ifdef MUX2TO1_SEL_SYNC_EN
    localparam int SYNC_D = 2;
`else
    localparam int SYNC_D = 0;
`endif
    localparam int MAX8 = 7;
    localparam int MAX1 = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic       sel, clr;

    logic [7:0] z8, zq8;
    logic       selq8, sat8;
    logic [2:0] cnt8;
    logic       z1, zq1, selq1, sat1;
    logic [1:0] cnt1;

    always #5 clk = ~clk;

    mux2to1 #(.WIDTH(8), .CNT_W(3)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_A(a), .i_B(b), .i_sel(sel), .i_clr(clr),
        .o_Z(z8), .o_Z_q(zq8), .o_sel_q(selq8), .o_sw_cnt(cnt8), .o_sw_sat(sat8)
    );

    mux2to1 #(.WIDTH(1), .CNT_W(2)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_A(a[0]), .i_B(b[0]), .i_sel(sel), .i_clr(clr),
        .o_Z(z1), .o_Z_q(zq1), .o_sel_q(selq1), .o_sw_cnt(cnt1), .o_sw_sat(sat1)
    );

    typedef struct {
        logic [7:0] zq;
        logic       selq;
        int         c8;
        int         c1;
    } exp_t;

    exp_t exp_q[$];
    bit   sel_hist[$];
    int   m_c8, m_c1;
    logic m_selq;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_c8 = 0;
        m_c1 = 0;
        m_selq = 1'b0;
        sel_hist.delete();
        for (int i = 0; i < SYNC_D; i++) sel_hist.push_back(1'b0);
    endtask

    // Drive one cycle of stimulus at the falling edge and predict the state after the next rising edge.
    task automatic step(input logic [7:0] na, input logic [7:0] nb, input logic ns, input logic nc);
        exp_t e;
        bit   eff;
        @(negedge clk);
        a = na; b = nb; sel = ns; clr = nc;
        #1;
        chk("z8_comb", 32'(z8), 32'(ns ? nb : na));
        chk("z1_comb", 32'(z1), 32'(ns ? nb[0] : na[0]));
        sel_hist.push_back(ns);
        eff = sel_hist.pop_front();
        if (nc) begin
            m_c8 = 0;
            m_c1 = 0;
        end else if (eff != m_selq) begin
            m_c8 = (m_c8 < MAX8) ? m_c8 + 1 : MAX8;
            m_c1 = (m_c1 < MAX1) ? m_c1 + 1 : MAX1;
        end
        m_selq = eff;
        e.zq = eff ? nb : na;
        e.selq = eff;
        e.c8 = m_c8;
        e.c1 = m_c1;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        repeat (2) @(posedge clk);
        #2;
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: registered outputs settle after each rising edge; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("zq8",   32'(zq8),   32'(e.zq));
                chk("selq8", 32'(selq8), 32'(e.selq));
                chk("cnt8",  32'(cnt8),  32'(e.c8));
                chk("sat8",  32'(sat8),  32'(e.c8 == MAX8));
                chk("zq1",   32'(zq1),   32'(e.zq[0]));
                chk("selq1", 32'(selq1), 32'(e.selq));
                chk("cnt1",  32'(cnt1),  32'(e.c1));
                chk("sat1",  32'(sat1),  32'(e.c1 == MAX1));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, expected finish before 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] tt;
        logic [2:0] idx;
        tt = 8'b1101_1000;
        rst_n = 1'b0; a = '0; b = '0; sel = 1'b0; clr = 1'b0;
        model_reset();
        #3;
        chk("rst_zq8",  32'(zq8),  32'd0);
        chk("rst_selq", 32'(selq8), 32'd0);
        chk("rst_cnt8", 32'(cnt8), 32'd0);
        chk("rst_sat8", 32'(sat8), 32'd0);

        // Truth table on the 1-bit instance, held in reset so only the combinational path matters.
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            a = {7'd0, idx[2]};
            b = {7'd0, idx[1]};
            sel = idx[0];
            #10;
            chk("truth_table", 32'(z1), 32'(tt[idx]));
        end
        a = '0; b = '0; sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Registered path.
        step(8'h00, 8'h00, 1'b0, 1'b0);
        step(8'h5A, 8'hA5, 1'b1, 1'b0);
        step(8'h5A, 8'hA5, 1'b1, 1'b0);
        drain();

        // Back to select 0, clear counters, then five toggles and three holds.
        step(8'h11, 8'h22, 1'b0, 1'b1);
        step(8'h11, 8'h22, 1'b0, 1'b1);
        step(8'h11, 8'h22, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(8'(i), 8'(~i), (i % 2 == 0), 1'b0);
        for (int i = 0; i < 3; i++) step(8'h33, 8'h44, 1'b1, 1'b0);
        drain();
        chk("toggle5_cnt8", 32'(cnt8), 32'd5);
        chk("sat_cnt1",     32'(cnt1), 32'd3);
        chk("sat_flag1",    32'(sat1), 32'd1);

        // One more toggle saturates nothing further on dut1; clear with a toggle wins.
        step(8'h01, 8'h02, 1'b0, 1'b0);
        step(8'h01, 8'h02, 1'b1, 1'b1);
        for (int i = 0; i < SYNC_D; i++) step(8'h01, 8'h02, 1'b1, 1'b1);
        drain();
        chk("clr_cnt8", 32'(cnt8), 32'd0);
        chk("clr_cnt1", 32'(cnt1), 32'd0);

        // Random traffic.
        repeat (300) step(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        drain();

        // Asynchronous reset in the middle of a cycle.
        step(8'hFF, 8'hFF, 1'b1, 1'b0);
        step(8'hFF, 8'hFF, 1'b1, 1'b0);
        drain();
        @(negedge clk);
        #2;
        a = 8'h01; b = 8'h00; sel = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_zq8",  32'(zq8),   32'd0);
        chk("midrst_selq", 32'(selq8), 32'd0);
        chk("midrst_cnt8", 32'(cnt8),  32'd0);
        chk("midrst_z8",   32'(z8),    32'h01);
        chk("midrst_z1",   32'(z1),    32'd1);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        repeat (100) step(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mux2to1
